oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 131 +++++++++++++
 tb/tb_oam_dma.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from {src_page,00} to FE00 in read/write pairs.
// Latency: a page write starts the transfer next cycle; the transfer takes 2*LENGTH cycles.
// Backpressure: none; the initiator bus is assumed to accept one strobe per cycle.
//
// Ports:
//   clockgb, resetn         clock, async active-low reset
//   address/indata/outdata  CPU responder bus; load/store are read/write strobes
//   m_address/m_outdata     initiator bus; m_indata returns one cycle after m_load
//   m_load/m_store          initiator read/write strobes
//   busy                    high while a transfer is running
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'hFF46,
  parameter int          LENGTH   = 160
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] m_address,
  output logic [7:0]  m_outdata,
  input  logic [7:0]  m_indata,
  output logic        m_load,
  output logic        m_store,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_index;
  logic [7:0]  w_next_index;
  logic [7:0]  r_src;
  logic [7:0]  w_page;
  logic        w_reg_wr;
  logic        w_unused;

  // outdata is a pure address decode, so the read strobe carries no information.
  assign w_unused = load;

  assign w_reg_wr = store && (address == REG_ADDR);

  // CPU-visible source-page register.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_src <= 8'h00;
    end else if (w_reg_wr) begin
      r_src <= indata;
    end
  end

  assign outdata = (address == REG_ADDR) ? r_src : 8'h00;

  // Pages E0..FF are echo RAM; fold them back onto C0..DF.
  assign w_page = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;

  // State register.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_index <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_index <= w_next_index;
    end
  end

  // Next-state logic. A page write restarts from byte 0 regardless of state;
  // the current cycle's strobe is unaffected because outputs decode r_state.
  always_comb begin
    w_next_state = r_state;
    w_next_index = r_index;
    if (w_reg_wr) begin
      w_next_state = S_READ;
      w_next_index = 8'h00;
    end else begin
      case (r_state)
        S_READ: begin
          w_next_state = S_WRITE;
        end
        S_WRITE: begin
          if (r_index == LAST_IDX) begin
            w_next_state = S_IDLE;
            w_next_index = 8'h00;
          end else begin
            w_next_state = S_READ;
            w_next_index = r_index + 8'h01;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_index = 8'h00;
        end
      endcase
    end
  end

  // Output decode. Index < 256 so the low byte never carries into the page.
  always_comb begin
    m_load    = 1'b0;
    m_store   = 1'b0;
    m_address = 16'h0000;
    m_outdata = 8'h00;
    busy      = 1'b0;
    case (r_state)
      S_READ: begin
        m_load    = 1'b1;
        m_address = {w_page, 8'h00} + {8'h00, r_index};
        busy      = 1'b1;
      end
      S_WRITE: begin
        m_store   = 1'b1;
        m_address = 16'hFE00 + {8'h00, r_index};
        m_outdata = m_indata;
        busy      = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

  localparam int LENGTH = 160;

  logic        clockgb;
  logic        resetn;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;
  logic [15:0] m_address;
  logic [7:0]  m_outdata;
  logic [7:0]  m_indata;
  logic        m_load;
  logic        m_store;
  logic        busy;

  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  dat;
  } txn_t;

  txn_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  oam_dma #(.REG_ADDR(16'hFF46), .LENGTH(LENGTH)) dut (
    .clockgb  (clockgb),
    .resetn   (resetn),
    .address  (address),
    .indata   (indata),
    .outdata  (outdata),
    .load     (load),
    .store    (store),
    .m_address(m_address),
    .m_outdata(m_outdata),
    .m_indata (m_indata),
    .m_load   (m_load),
    .m_store  (m_store),
    .busy     (busy)
  );

  initial clockgb = 1'b0;
  always #5 clockgb = ~clockgb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the DMA: a fixed hash of the address.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory responder: data for a read appears one cycle after m_load.
  initial begin
    logic        cap_ld;
    logic [15:0] cap_a;
    m_indata = 8'h00;
    forever begin
      @(negedge clockgb);
      cap_ld = m_load;
      cap_a  = m_address;
      @(posedge clockgb);
      #1;
      m_indata = cap_ld ? mem_f(cap_a) : 8'hEE;
    end
  end

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    txn_t e;
    forever begin
      @(negedge clockgb);
      if (m_load && m_store) chk("both_strobes", 1, 0);
      if (m_load || m_store) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {m_store, m_address}, 0);
        end else begin
          e = sb.pop_front();
          chk("kind", {31'd0, m_store}, {31'd0, e.is_wr});
          chk("m_address", {16'd0, m_address}, {16'd0, e.addr});
          if (e.is_wr) chk("m_outdata", {24'd0, m_outdata}, {24'd0, e.dat});
        end
      end
    end
  end

  // Write the page register and push the expected bus traffic.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    txn_t        first;
    txn_t        t;
    logic [7:0]  pg;
    logic [15:0] src;
    @(posedge clockgb);
    #1;
    address = a;
    indata  = d;
    store   = 1'b1;
    if (a == 16'hFF46) begin
      // The strobe of the current cycle still happens; the rest is dropped.
      if (sb.size() > 0) begin
        first = sb[0];
        sb.delete();
        sb.push_back(first);
      end
      pg = (d >= 8'hE0) ? d - 8'h20 : d;
      for (int i = 0; i < LENGTH; i++) begin
        src     = {pg, 8'(i)};
        t.is_wr = 1'b0; t.addr = src;                   t.dat = 8'h00;
        sb.push_back(t);
        t.is_wr = 1'b1; t.addr = 16'hFE00 + 16'(i);     t.dat = mem_f(src);
        sb.push_back(t);
      end
    end
    @(posedge clockgb);
    #1;
    store   = 1'b0;
    address = 16'h0000;
  endtask

  // Count busy cycles until idle, bounded.
  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    forever begin
      @(negedge clockgb);
      if (!busy) break;
      n++;
      if (n > 1000) break;
    end
    chk(tag, n, exp_cycles);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    resetn  = 1'b0;
    address = 16'hFF46;
    indata  = 8'h00;
    load    = 1'b0;
    store   = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_m_load", {31'd0, m_load}, 0);
    chk("rst_m_store", {31'd0, m_store}, 0);
    chk("rst_m_address", {16'd0, m_address}, 0);
    chk("rst_m_outdata", {24'd0, m_outdata}, 0);
    chk("rst_reg", {24'd0, outdata}, 0);
    @(posedge clockgb);
    #1;
    resetn  = 1'b1;
    address = 16'h0000;

    // Basic transfer from page C1.
    do_write(16'hFF46, 8'hC1);
    @(negedge clockgb);
    chk("busy_next_cycle", {31'd0, busy}, 1);
    wait_idle("c1_cycles", LENGTH * 2 - 1);
    chk("idle_m_address", {16'd0, m_address}, 0);
    chk("idle_m_outdata", {24'd0, m_outdata}, 0);

    // Echo-RAM page folds onto C2.
    do_write(16'hFF46, 8'hE2);
    wait_idle("e2_cycles", LENGTH * 2);

    // Restart mid-transfer at cycle 100.
    do_write(16'hFF46, 8'hC0);
    repeat (99) @(negedge clockgb);
    do_write(16'hFF46, 8'hD0);
    wait_idle("restart_cycles", LENGTH * 2);

    // Reset during WRITE of byte 50.
    do_write(16'hFF46, 8'hC3);
    repeat (101) @(negedge clockgb);
    @(posedge clockgb);
    #1;
    chk("pre_rst_store", {31'd0, m_store}, 1);
    resetn  = 1'b0;
    address = 16'hFF46;
    sb.delete();
    #1;
    chk("abort_m_store", {31'd0, m_store}, 0);
    chk("abort_m_load", {31'd0, m_load}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_reg", {24'd0, outdata}, 0);
    @(posedge clockgb);
    #1;
    resetn = 1'b1;
    wait_idle("post_rst_quiet", 0);
    repeat (50) @(negedge clockgb);
    chk("post_rst_busy", {31'd0, busy}, 0);

    // Register readback and foreign-address decode.
    do_write(16'hFF46, 8'h80);
    wait_idle("p80_cycles", LENGTH * 2);
    address = 16'hFF46;
    load    = 1'b1;
    #1;
    chk("read_ff46", {24'd0, outdata}, 32'h80);
    address = 16'hFF47;
    #1;
    chk("read_ff47", {24'd0, outdata}, 0);
    load = 1'b0;
    do_write(16'hFF47, 8'h55);
    repeat (20) @(negedge clockgb);
    chk("ff47_no_busy", {31'd0, busy}, 0);
    address = 16'hFF46;
    #1;
    chk("ff47_reg_kept", {24'd0, outdata}, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
